// File: rtl/read2control.sv
`timescale 1ns/1ps
// read2control
// Read side of the line buffer. It drains the X_MAC*X_MESH BRAM bank through
// port B one rectangular tile at a time: line_num lines of linelen words, with
// line starts line_stride apart. It generates one broadcast address/enable,
// tracks the fixed BRAM read latency with a valid shift register, and masks
// inactive MAC columns to zero. Words reach the mesh through a small
// show-ahead FIFO.
//
// Handshake: a word moves to the mesh on every rising edge where
// out_valid && out_ready. out_valid never drops until that word is taken, and
// out_data stays stable while out_valid is high and out_ready is low.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   conf            one-cycle start pulse; tile parameters sampled with it
//   st_addr, linelen, line_num, line_stride, valid_mac   tile description
//   addrb, enb      BRAM port-B address (replicated per buffer) and enable
//   doutb           BRAM read data, slot (i,j) at j*DATA_LEN + i*DATA_LEN*X_MAC
//   out_data, out_valid, out_ready   stream to the mesh, same slot layout
//   busy, done      tile in progress / one-cycle completion pulse
//   state_dbg       current FSM state (IDLE=0, RUN=1, DRAIN=2)
module read2control #(
  parameter int X_MAC      = 4,
  parameter int X_MESH     = 16,
  parameter int ADDR_LEN   = 13,
  parameter int DATA_LEN   = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int BUFFER_NUM = X_MAC * X_MESH,
  parameter int DATAWIDTH  = BUFFER_NUM * DATA_LEN,
  parameter int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 conf,
  input  logic [ADDR_LEN-1:0]  st_addr,
  input  logic [ADDR_LEN-1:0]  linelen,
  input  logic [7:0]           line_num,
  input  logic [ADDR_LEN-1:0]  line_stride,
  input  logic [1:0]           valid_mac,
  output logic [ADDRWIDTH-1:0] addrb,
  output logic                 enb,
  input  logic [DATAWIDTH-1:0] doutb,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Occupancy arithmetic width; FIFO_DEPTH + RD_LAT + 2 always fits.
  localparam int CW = 8;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [1:0]          state;
  logic [ADDR_LEN-1:0] line_base;
  logic [ADDR_LEN-1:0] len_q;
  logic [7:0]          num_q;
  logic [ADDR_LEN-1:0] stride_q;
  logic [1:0]          vm_q;
  logic [ADDR_LEN-1:0] word_cnt;
  logic [7:0]          line_cnt;
  logic [ADDR_LEN-1:0] addr_q;
  logic                enb_q;
  logic [RD_LAT-1:0]   vpipe;
  logic                busy_q;
  logic                done_q;

  logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_count;

  logic [CW-1:0]        inflight;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic                 last_word;
  logic                 last_line;
  logic                 drain_done;
  logic [DATAWIDTH-1:0] masked;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reads in flight: the one currently on the enb register (not yet sampled
  // by the BRAM) plus every stage of the latency pipe.
  always_comb begin
    inflight = CW'(enb_q);
    for (int k = 0; k < RD_LAT; k++) begin
      inflight = inflight + CW'(vpipe[k]);
    end
  end

  assign push = vpipe[RD_LAT-1];
  assign pop  = (fifo_count != '0) && out_ready;

  // Credit rule: every issued read already owns a FIFO slot, so the FIFO can
  // never overflow. A pop at this edge frees a slot for this edge's issue.
  assign issue = (state == RUN) &&
                 ((fifo_count + inflight + CW'(1)) <= (CW'(FIFO_DEPTH) + CW'(pop)));

  assign last_word = (word_cnt == len_q - ADDR_LEN'(1));
  assign last_line = (line_cnt == num_q - 8'd1);

  // Finish at the edge that takes the last word, so done rises the cycle
  // after the final handshake and never overlaps out_valid.
  assign drain_done = (state == DRAIN) && (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  // Columns above valid_mac are zeroed as they enter the FIFO.
  always_comb begin
    masked = '0;
    for (int i = 0; i < X_MESH; i++) begin
      for (int j = 0; j < X_MAC; j++) begin
        if (j <= int'(vm_q)) begin
          masked[j*DATA_LEN + i*DATA_LEN*X_MAC +: DATA_LEN] =
            doutb[j*DATA_LEN + i*DATA_LEN*X_MAC +: DATA_LEN];
        end
      end
    end
  end

  // Control FSM and address generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      line_base <= '0;
      len_q     <= '0;
      num_q     <= '0;
      stride_q  <= '0;
      vm_q      <= '0;
      word_cnt  <= '0;
      line_cnt  <= '0;
      addr_q    <= '0;
      enb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      enb_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (conf) begin
            line_base <= st_addr;
            len_q     <= linelen;
            num_q     <= line_num;
            stride_q  <= line_stride;
            vm_q      <= valid_mac;
            word_cnt  <= '0;
            line_cnt  <= '0;
            busy_q    <= 1'b1;
            state     <= ((linelen == '0) || (line_num == 8'd0)) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            enb_q  <= 1'b1;
            addr_q <= line_base + word_cnt;
            if (last_word) begin
              word_cnt  <= '0;
              line_base <= line_base + stride_q;
              if (last_line) begin
                state <= DRAIN;
              end else begin
                line_cnt <= line_cnt + 8'd1;
              end
            end else begin
              word_cnt <= word_cnt + ADDR_LEN'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latency tracker: stage 0 is set at the edge where the BRAM samples enb,
  // so the last stage is high exactly at the edge the read data is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= enb_q;
      for (int k = 1; k < RD_LAT; k++) begin
        vpipe[k] <= vpipe[k-1];
      end
    end
  end

  // FIFO storage has no reset; the count and pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= masked;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign addrb     = {BUFFER_NUM{addr_q}};
  assign enb       = enb_q;
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state;

endmodule
